wb_master_cmd: RTL and testbench
================================

WB_MASTER_CMD -- requirements
Module: wb_master_cmd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width (8/16/32/64).
REQ-003 SHALL have parameter GRANULE, default 8, select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam).
REQ-004 SHALL have parameter TIMEOUT, default 255, max bus-phase cycles before abort (1..65535).
REQ-005 SHALL have ports:
 clk_i  in  1  clock, all logic on rising edge
 rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
 cmd_valid_i  in  1  command offered
 cmd_ready_o  out  1  command accepted when valid&ready
 cmd_we_i  in  1  1=write, 0=read
 cmd_adr_i  in  ADDR_WIDTH  target address
 cmd_dat_i  in  DATA_WIDTH  write data
 cmd_sel_i  in  SEL_WIDTH  byte-lane select
 rsp_valid_o  out  1  response available
 rsp_ready_i  in  1  response consumed when valid&ready
 rsp_dat_o  out  DATA_WIDTH  read data (0 for writes/errors)
 rsp_err_o  out  1  cycle ended by ERR_I or timeout
 rsp_timeout_o  out  1  cycle ended by timeout
 cyc_o, stb_o, we_o  out  1  Wishbone B4 classic master controls
 adr_o  out  ADDR_WIDTH; dat_o  out  DATA_WIDTH; sel_o  out  SEL_WIDTH
 dat_i  in  DATA_WIDTH; ack_i  in  1; err_i  in  1  slave returns

Function
REQ-006 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; one outstanding command maximum.
REQ-007 IDLE: cmd_ready_o=1 (decoded from state only, no dependency on cmd_valid_i); all other states cmd_ready_o=0.
REQ-008 On cmd_valid_i&cmd_ready_o at edge N: register adr/dat/sel/we onto bus outputs, enter BUS; cyc_o=stb_o=1 from cycle N+1.
REQ-009 BUS: adr_o, dat_o, sel_o, we_o held stable; cyc_o=stb_o=1 continuously.
REQ-010 BUS, ack_i=1 and err_i=0 sampled: read -> rsp_dat_o<=dat_i; write -> rsp_dat_o<=0; rsp_err_o<=0; enter RESP.
REQ-011 BUS, err_i=1 sampled (regardless of ack_i): rsp_err_o<=1, rsp_dat_o<=0, rsp_timeout_o<=0; enter RESP.
REQ-012 BUS timeout counter: cleared on BUS entry, +1 per BUS cycle without ack/err; reaching TIMEOUT -> rsp_err_o<=1, rsp_timeout_o<=1, rsp_dat_o<=0, enter RESP; ack/err on that same edge takes priority over timeout.
REQ-013 Counter SHALL be wide enough for TIMEOUT, no wrap-around before terminal count.
REQ-014 RESP: cyc_o=stb_o=0 (at least one idle bus cycle between transfers guaranteed), rsp_valid_o=1; response outputs stable until rsp_ready_i sampled 1.
REQ-015 RESP with rsp_ready_i=1: rsp_valid_o<=0, enter IDLE; next command acceptable one cycle later (no same-cycle bypass).
REQ-016 ack_i/err_i outside BUS SHALL be ignored.
REQ-017 cmd_* inputs SHALL be ignored except on the accept edge.
REQ-018 rsp_dat_o/rsp_err_o/rsp_timeout_o SHALL hold last values in IDLE/BUS.

Reset
REQ-019 rst_n_i=0 SHALL immediately (asynchronously) force: state IDLE, cyc_o=stb_o=we_o=0, adr_o=dat_o=sel_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=rsp_timeout_o=0, counter=0.
REQ-020 Reset during BUS or RESP SHALL abort the cycle with no response delivered; cmd_ready_o=1 on first clock after rst_n_i deasserts.
REQ-021 Reset deassertion is assumed synchronised externally; first active edge after release behaves as IDLE.

Verification
REQ-022 Write: cmd we=1 adr=0x0002 dat=0xDEADBEEF sel=0xF, slave acks 2 cycles after stb -> bus signals as commanded, stb 3 cycles, rsp_valid=1 err=0 dat=0.
REQ-023 Read: after REQ-022, cmd we=0 adr=0x0002, slave returns 0xDEADBEEF with ack -> rsp_dat_o=0xDEADBEEF, err=0, stb low in RESP.
REQ-024 Error: slave asserts ack_i=1 and err_i=1 together -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
REQ-025 Timeout: TIMEOUT=4, slave never responds -> stb_o high exactly 4 cycles, then rsp_err_o=1, rsp_timeout_o=1.
REQ-026 Backpressure: rsp_ready_i=0 for 10 cycles -> rsp_valid_o and data stable, cmd_ready_o=0, stb_o=0 throughout; accept -> cmd_ready_o=1 next cycle.
REQ-027 Async reset: rst_n_i pulsed low mid-BUS between edges -> cyc_o/stb_o drop before next edge, no rsp_valid_o, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/wb_master_cmd.sv
// Single-outstanding Wishbone B4 classic master: converts one valid/ready command into one bus cycle and one response.
// Latency: bus cycle starts the cycle after accept; response appears the cycle after ack/err/timeout; the response is held until consumed.
module wb_master_cmd #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int GRANULE     = 8,
  parameter int TIMEOUT     = 255,
  localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 accept;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (ack_i || err_i || (cnt_q == CNT_LAST)) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controls are pure state decodes so an asynchronous reset drops them at once.
  assign cmd_ready_o = (state_q == S_IDLE);
  assign cyc_o       = (state_q == S_BUS);
  assign stb_o       = (state_q == S_BUS);
  assign rsp_valid_o = (state_q == S_RESP);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
      sel_o         <= '0;
      cnt_q         <= '0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (accept) begin
        we_o  <= cmd_we_i;
        adr_o <= cmd_adr_i;
        dat_o <= cmd_dat_i;
        sel_o <= cmd_sel_i;
        cnt_q <= '0;
      end
      // err wins over ack, and any slave reply wins over the terminal count.
      if (state_q == S_BUS) begin
        if (err_i) begin
          rsp_dat_o     <= '0;
          rsp_err_o     <= 1'b1;
          rsp_timeout_o <= 1'b0;
        end else if (ack_i) begin
          rsp_dat_o     <= we_o ? '0 : dat_i;
          rsp_err_o     <= 1'b0;
          rsp_timeout_o <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_o     <= '0;
          rsp_err_o     <= 1'b1;
          rsp_timeout_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Directed bench for wb_master_cmd (TIMEOUT=4): write, read, error, timeout, backpressure, async reset, back-to-back.
module tb_wb_master_cmd;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [15:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        cyc_o, stb_o, we_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;

  int checks = 0;
  int errors = 0;

  wb_master_cmd #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  // Offer a command at the current falling edge; returns at the falling edge of the first bus cycle
  // with the command inputs scrambled so any late sampling would be visible.
  task automatic issue_cmd(input logic we, input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~we;
    cmd_adr_i   = 16'hFFFF;
    cmd_dat_i   = 32'h0BAD_0BAD;
    cmd_sel_i   = 4'h0;
  endtask

  // Slave model: counts cycles with stb high, replies during cycle resp_at (0 = never); bounded.
  task automatic wait_bus(input int resp_at, input logic a, input logic e, input logic [31:0] rd, output int n);
    n = 0;
    while (stb_o && n < 50) begin
      n++;
      if (n == resp_at) begin
        ack_i = a;
        err_i = e;
        dat_i = rd;
      end
      @(negedge clk_i);
      ack_i = 1'b0;
      err_i = 1'b0;
      dat_i = 32'h0;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_o); end
    checks++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin errors++; $display("FAIL reset_bus_ctl got=%b exp=000", {cyc_o, stb_o, we_o}); end
    checks++; if ({adr_o, dat_o, sel_o} !== 52'h0) begin errors++; $display("FAIL reset_bus_dat got=%h exp=0", {adr_o, dat_o, sel_o}); end
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_dat_o} !== 35'h0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_dat_o}); end
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_write();
    int n;
    issue_cmd(1'b1, 16'h0002, 32'hDEADBEEF, 4'hF);
    checks++; if ({cyc_o, stb_o, we_o, cmd_ready_o} !== 4'b1110) begin errors++; $display("FAIL wr_ctl got=%b exp=1110", {cyc_o, stb_o, we_o, cmd_ready_o}); end
    checks++; if (adr_o !== 16'h0002) begin errors++; $display("FAIL wr_adr got=%h exp=0002", adr_o); end
    checks++; if (dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_dat got=%h exp=deadbeef", dat_o); end
    checks++; if (sel_o !== 4'hF) begin errors++; $display("FAIL wr_sel got=%h exp=f", sel_o); end
    wait_bus(3, 1'b1, 1'b0, 32'h1234_5678, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL wr_stb_cycles got=%0d exp=3", n); end
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, stb_o} !== 4'b1000) begin errors++; $display("FAIL wr_rsp_flags got=%b exp=1000", {rsp_valid_o, rsp_err_o, rsp_timeout_o, stb_o}); end
    checks++; if (rsp_dat_o !== 32'h0) begin errors++; $display("FAIL wr_rsp_dat got=%h exp=0", rsp_dat_o); end
    finish_rsp();
    checks++; if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin errors++; $display("FAIL wr_after_hs got=%b exp=01", {rsp_valid_o, cmd_ready_o}); end
  endtask

  task automatic test_read_backpressure();
    int n;
    logic ok;
    issue_cmd(1'b0, 16'h0002, 32'h0, 4'hF);
    checks++; if ({we_o, adr_o} !== {1'b0, 16'h0002}) begin errors++; $display("FAIL rd_bus got=%h exp=00002", {we_o, adr_o}); end
    wait_bus(2, 1'b1, 1'b0, 32'hDEADBEEF, n);
    checks++; if (rsp_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat got=%h exp=deadbeef", rsp_dat_o); end
    checks++; if ({rsp_valid_o, rsp_err_o, stb_o, cyc_o} !== 4'b1000) begin errors++; $display("FAIL rd_flags got=%b exp=1000", {rsp_valid_o, rsp_err_o, stb_o, cyc_o}); end
    // Stray slave replies during RESP must not disturb the held response.
    for (int i = 0; i < 10; i++) begin
      ok = (rsp_valid_o === 1'b1) && (rsp_dat_o === 32'hDEADBEEF) && (cmd_ready_o === 1'b0) &&
           (stb_o === 1'b0) && (rsp_err_o === 1'b0);
      checks++; if (!ok) begin errors++; $display("FAIL bp_hold cycle=%0d got valid=%b dat=%h rdy=%b stb=%b exp 1/deadbeef/0/0", i, rsp_valid_o, rsp_dat_o, cmd_ready_o, stb_o); end
      ack_i = 1'b1;
      err_i = 1'b1;
      @(negedge clk_i);
    end
    ack_i = 1'b0;
    err_i = 1'b0;
    finish_rsp();
    checks++; if ({cmd_ready_o, rsp_valid_o} !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", {cmd_ready_o, rsp_valid_o}); end
    checks++; if (rsp_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_idle_hold got=%h exp=deadbeef", rsp_dat_o); end
  endtask

  task automatic test_error();
    int n;
    issue_cmd(1'b0, 16'h0004, 32'h0, 4'h3);
    wait_bus(2, 1'b1, 1'b1, 32'hCAFEF00D, n);
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b110) begin errors++; $display("FAIL err_flags got=%b exp=110", {rsp_valid_o, rsp_err_o, rsp_timeout_o}); end
    checks++; if (rsp_dat_o !== 32'h0) begin errors++; $display("FAIL err_dat got=%h exp=0", rsp_dat_o); end
    finish_rsp();
    checks++; if (rsp_err_o !== 1'b1) begin errors++; $display("FAIL err_idle_hold got=%b exp=1", rsp_err_o); end
  endtask

  task automatic test_timeout();
    int n;
    issue_cmd(1'b1, 16'h0010, 32'h5555_AAAA, 4'h1);
    wait_bus(0, 1'b0, 1'b0, 32'h0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL to_stb_cycles got=%0d exp=4", n); end
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_dat_o} !== {3'b111, 32'h0}) begin errors++; $display("FAIL to_rsp got=%h exp=%h", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_dat_o}, {3'b111, 32'h0}); end
    finish_rsp();
  endtask

  task automatic test_ack_at_limit();
    int n;
    issue_cmd(1'b0, 16'h0020, 32'h0, 4'hF);
    wait_bus(4, 1'b1, 1'b0, 32'hA5A5_5A5A, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL lim_stb_cycles got=%0d exp=4", n); end
    checks++; if ({rsp_err_o, rsp_timeout_o, rsp_dat_o} !== {2'b00, 32'hA5A5_5A5A}) begin errors++; $display("FAIL lim_rsp got=%h exp=%h", {rsp_err_o, rsp_timeout_o, rsp_dat_o}, {2'b00, 32'hA5A5_5A5A}); end
    finish_rsp();
  endtask

  task automatic test_async_reset();
    issue_cmd(1'b1, 16'h0033, 32'h1111_2222, 4'hC);
    checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL ar_pre_stb got=%b exp=1", stb_o); end
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if ({cyc_o, stb_o, we_o, rsp_valid_o} !== 4'b0000) begin errors++; $display("FAIL ar_ctl got=%b exp=0000", {cyc_o, stb_o, we_o, rsp_valid_o}); end
    checks++; if ({adr_o, rsp_dat_o} !== 48'h0) begin errors++; $display("FAIL ar_dat got=%h exp=0", {adr_o, rsp_dat_o}); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if ({cmd_ready_o, rsp_valid_o, cyc_o} !== 3'b100) begin errors++; $display("FAIL ar_after cycle=%0d got=%b exp=100", i, {cmd_ready_o, rsp_valid_o, cyc_o}); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 16'h0008;
    cmd_dat_i   = 32'h0000_0008;
    cmd_sel_i   = 4'hF;
    @(negedge clk_i);
    checks++; if ({stb_o, adr_o} !== {1'b1, 16'h0008}) begin errors++; $display("FAIL b2b_first got=%h exp=10008", {stb_o, adr_o}); end
    cmd_adr_i = 16'h0009;
    wait_bus(1, 1'b1, 1'b0, 32'h0, n);
    checks++; if ({rsp_valid_o, cmd_ready_o} !== 2'b10) begin errors++; $display("FAIL b2b_resp got=%b exp=10", {rsp_valid_o, cmd_ready_o}); end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checks++; if ({cmd_ready_o, stb_o} !== 2'b10) begin errors++; $display("FAIL b2b_gap got=%b exp=10", {cmd_ready_o, stb_o}); end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checks++; if ({stb_o, adr_o} !== {1'b1, 16'h0009}) begin errors++; $display("FAIL b2b_second got=%h exp=10009", {stb_o, adr_o}); end
    wait_bus(1, 1'b1, 1'b0, 32'h0, n);
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
    test_error();
    test_timeout();
    test_ack_at_limit();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
